// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the two-master data-memory arbiter: byte-lane mask
// encodings, the lane-mask legality check and the arbiter state encoding.
package dmem_arbiter_pkg;

  localparam logic [3:0] AMP_W  = 4'b1111;
  localparam logic [3:0] AMP_H0 = 4'b0011;
  localparam logic [3:0] AMP_H1 = 4'b1100;
  localparam logic [3:0] AMP_B0 = 4'b0001;
  localparam logic [3:0] AMP_B1 = 4'b0010;
  localparam logic [3:0] AMP_B2 = 4'b0100;
  localparam logic [3:0] AMP_B3 = 4'b1000;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_OWN1 = 1'b1
  } arb_state_e;

  typedef enum logic {
    M0 = 1'b0,
    M1 = 1'b1
  } master_e;

  // Only naturally aligned word, halfword and byte lanes are accepted.
  function automatic logic legal_amp(input logic [3:0] amp);
    logic ok;
    case (amp)
      AMP_W, AMP_H0, AMP_H1, AMP_B0, AMP_B1, AMP_B2, AMP_B3: ok = 1'b1;
      default:                                              ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/dmem_rsp_reg.sv
// Per-master response register: read-valid strobe, captured read word and
// the one-cycle illegal-write error pulse.
module dmem_rsp_reg
  import dmem_arbiter_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            rd_gnt,
  input  logic            wr_bad,
  input  logic [XLEN-1:0] rd_word,
  output logic            rvalid,
  output logic [XLEN-1:0] rdata,
  output logic            err
);

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values, independent of block ordering.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rvalid <= 1'b0;
      rdata  <= '0;
      err    <= 1'b0;
    end else begin
      rvalid <= rd_gnt;
      err    <= wr_bad;
      if (rd_gnt) rdata <= rd_word;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one data-memory port between the CPU LSU (m0)
// and a DMA/loader master (m1), with a bounded m1 burst lock.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int MAX_HOLD = 4
) (
  input  logic            clk,
  input  logic            rstn,

  input  logic            m0_req,
  input  logic            m0_we,
  input  logic [3:0]      m0_amp,
  input  logic [XLEN-1:0] m0_addr,
  input  logic [XLEN-1:0] m0_wdata,
  output logic            m0_gnt,
  output logic            m0_rvalid,
  output logic [XLEN-1:0] m0_rdata,
  output logic            m0_err,

  input  logic            m1_req,
  input  logic            m1_we,
  input  logic [3:0]      m1_amp,
  input  logic [XLEN-1:0] m1_addr,
  input  logic [XLEN-1:0] m1_wdata,
  input  logic            m1_lock,
  output logic            m1_gnt,
  output logic            m1_rvalid,
  output logic [XLEN-1:0] m1_rdata,
  output logic            m1_err,

  output logic            mem_we,
  output logic [3:0]      mem_amp,
  output logic [XLEN-1:0] mem_a,
  output logic [XLEN-1:0] mem_wd,
  input  logic [XLEN-1:0] mem_rd
);

  localparam int                HOLD_W   = $clog2(MAX_HOLD + 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD);
  localparam logic [HOLD_W-1:0] HOLD_ONE = HOLD_W'(1);

  arb_state_e        state;
  logic [HOLD_W-1:0] hold;
  master_e           last;

  logic              any_win;
  master_e           winner;
  logic              hold_full;
  logic              win_we;
  logic [3:0]        win_amp;
  logic [XLEN-1:0]   win_a;
  logic [XLEN-1:0]   win_wd;
  logic              win_amp_ok;

  // NOTE: every signal assigned here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    // Reset also blocks grants, so a held reset quiets the memory port at once.
    any_win   = rstn & (m0_req | m1_req);
    hold_full = (state == ST_OWN1) && (hold == HOLD_MAX) && m0_req;
    winner    = M0;
    if (m0_req && m1_req) begin
      if (state == ST_OWN1) winner = hold_full ? M0 : M1;
      else                  winner = (last == M0) ? M1 : M0;
    end else if (m1_req) begin
      winner = M1;
    end
  end

  assign m0_gnt = any_win && (winner == M0);
  assign m1_gnt = any_win && (winner == M1);

  always_comb begin
    win_we  = 1'b0;
    win_amp = '0;
    win_a   = '0;
    win_wd  = '0;
    if (m0_gnt) begin
      win_we  = m0_we;
      win_amp = m0_amp;
      win_a   = m0_addr;
      win_wd  = m0_wdata;
    end else if (m1_gnt) begin
      win_we  = m1_we;
      win_amp = m1_amp;
      win_a   = m1_addr;
      win_wd  = m1_wdata;
    end
  end

  assign win_amp_ok = legal_amp(win_amp);
  assign mem_we     = win_we & win_amp_ok;
  assign mem_amp    = win_amp;
  assign mem_a      = win_a;
  assign mem_wd     = win_wd;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= ST_IDLE;
      hold  <= '0;
      last  <= M1;
    end else begin
      if (any_win) last <= winner;
      case (state)
        ST_IDLE: begin
          if (m1_gnt && m1_lock) begin
            state <= ST_OWN1;
            hold  <= HOLD_ONE;
          end
        end
        ST_OWN1: begin
          if (!m1_lock || !m1_req || hold_full) begin
            state <= ST_IDLE;
            hold  <= '0;
          end else if (m0_req && (hold != HOLD_MAX)) begin
            // Only grants that actually make m0 wait count toward the bound.
            hold <= hold + HOLD_ONE;
          end
        end
        default: begin
          state <= ST_IDLE;
          hold  <= '0;
        end
      endcase
    end
  end

  dmem_rsp_reg #(.XLEN(XLEN)) u_rsp0 (
    .clk     (clk),
    .rstn    (rstn),
    .rd_gnt  (m0_gnt & ~m0_we),
    .wr_bad  (m0_gnt & m0_we & ~legal_amp(m0_amp)),
    .rd_word (mem_rd),
    .rvalid  (m0_rvalid),
    .rdata   (m0_rdata),
    .err     (m0_err)
  );

  dmem_rsp_reg #(.XLEN(XLEN)) u_rsp1 (
    .clk     (clk),
    .rstn    (rstn),
    .rd_gnt  (m1_gnt & ~m1_we),
    .wr_bad  (m1_gnt & m1_we & ~legal_amp(m1_amp)),
    .rd_word (mem_rd),
    .rvalid  (m1_rvalid),
    .rdata   (m1_rdata),
    .err     (m1_err)
  );

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: grants checked in the driver, read/err
// responses checked by a negedge monitor against per-master queues.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rstn;
  logic        m0_req, m0_we, m1_req, m1_we, m1_lock;
  logic [3:0]  m0_amp, m1_amp;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic        m0_gnt, m0_rvalid, m0_err, m1_gnt, m1_rvalid, m1_err;
  logic [31:0] m0_rdata, m1_rdata;
  logic        mem_we;
  logic [3:0]  mem_amp;
  logic [31:0] mem_a, mem_wd, mem_rd;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  typedef struct {
    bit          is_err;
    logic [31:0] data;
    int          cyc;
  } rsp_t;

  rsp_t q0[$];
  rsp_t q1[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dmem_arbiter #(.XLEN(32), .MAX_HOLD(4)) dut (
    .clk(clk), .rstn(rstn),
    .m0_req(m0_req), .m0_we(m0_we), .m0_amp(m0_amp), .m0_addr(m0_addr),
    .m0_wdata(m0_wdata), .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid),
    .m0_rdata(m0_rdata), .m0_err(m0_err),
    .m1_req(m1_req), .m1_we(m1_we), .m1_amp(m1_amp), .m1_addr(m1_addr),
    .m1_wdata(m1_wdata), .m1_lock(m1_lock), .m1_gnt(m1_gnt),
    .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata), .m1_err(m1_err),
    .mem_we(mem_we), .mem_amp(mem_amp), .mem_a(mem_a), .mem_wd(mem_wd),
    .mem_rd(mem_rd)
  );

  // dmem model: combinational read; sub-word stores take their data from the
  // low bits of mem_wd and place it in the lane(s) selected by mem_amp.
  logic [31:0] mem [0:63];
  assign mem_rd = mem[mem_a[7:2]];

  always @(posedge clk) begin
    if (mem_we) begin
      case (mem_amp)
        4'b1111: mem[mem_a[7:2]]        <= mem_wd;
        4'b0011: mem[mem_a[7:2]][15:0]  <= mem_wd[15:0];
        4'b1100: mem[mem_a[7:2]][31:16] <= mem_wd[15:0];
        4'b0001: mem[mem_a[7:2]][7:0]   <= mem_wd[7:0];
        4'b0010: mem[mem_a[7:2]][15:8]  <= mem_wd[7:0];
        4'b0100: mem[mem_a[7:2]][23:16] <= mem_wd[7:0];
        4'b1000: mem[mem_a[7:2]][31:24] <= mem_wd[7:0];
        default: ;
      endcase
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic expect_rd(input int m, input logic [31:0] d);
    rsp_t e;
    e.is_err = 1'b0;
    e.data   = d;
    e.cyc    = cyc + 1;
    if (m == 0) q0.push_back(e); else q1.push_back(e);
  endtask

  task automatic expect_err(input int m);
    rsp_t e;
    e.is_err = 1'b1;
    e.data   = '0;
    e.cyc    = cyc + 1;
    if (m == 0) q0.push_back(e); else q1.push_back(e);
  endtask

  task automatic mon_one(input int m, input logic rv, input logic er, input logic [31:0] rd);
    rsp_t e;
    if (rv || er) begin
      if ((m == 0 && q0.size() == 0) || (m == 1 && q1.size() == 0)) begin
        check($sformatf("m%0d unexpected rsp {rvalid,err}", m), {30'd0, rv, er}, 32'd0);
      end else begin
        e = (m == 0) ? q0.pop_front() : q1.pop_front();
        check($sformatf("m%0d rsp {rvalid,err}", m), {30'd0, rv, er},
              e.is_err ? 32'd1 : 32'd2);
        check($sformatf("m%0d rsp cycle", m), cyc, e.cyc);
        if (!e.is_err) check($sformatf("m%0d rdata", m), rd, e.data);
      end
    end
  endtask

  always @(negedge clk) begin
    mon_one(0, m0_rvalid, m0_err, m0_rdata);
    mon_one(1, m1_rvalid, m1_err, m1_rdata);
  end

  task automatic set_m0(input logic r, input logic w, input logic [3:0] a,
                        input logic [31:0] ad, input logic [31:0] wd);
    m0_req = r; m0_we = w; m0_amp = a; m0_addr = ad; m0_wdata = wd;
  endtask

  task automatic set_m1(input logic r, input logic w, input logic [3:0] a,
                        input logic [31:0] ad, input logic [31:0] wd);
    m1_req = r; m1_we = w; m1_amp = a; m1_addr = ad; m1_wdata = wd;
  endtask

  task automatic sample(input logic eg0, input logic eg1, input string nm);
    @(negedge clk);
    check({nm, " m0_gnt"}, {31'd0, m0_gnt}, {31'd0, eg0});
    check({nm, " m1_gnt"}, {31'd0, m1_gnt}, {31'd0, eg1});
  endtask

  task automatic advance;
    @(posedge clk);
    #1;
  endtask

  task automatic step(input logic eg0, input logic eg1, input string nm);
    sample(eg0, eg1, nm);
    advance();
  endtask

  task automatic do_reset;
    set_m0(0, 0, 4'h0, 32'h0, 32'h0);
    set_m1(0, 0, 4'h0, 32'h0, 32'h0);
    m1_lock = 1'b0;
    rstn = 1'b0;
    advance();
    advance();
    @(negedge clk);
    rstn = 1'b1;
    advance();
  endtask

  task automatic check_quiet(input string nm);
    check({nm, " m0_gnt"},    {31'd0, m0_gnt},    32'd0);
    check({nm, " m1_gnt"},    {31'd0, m1_gnt},    32'd0);
    check({nm, " m0_rvalid"}, {31'd0, m0_rvalid}, 32'd0);
    check({nm, " m1_rvalid"}, {31'd0, m1_rvalid}, 32'd0);
    check({nm, " m0_err"},    {31'd0, m0_err},    32'd0);
    check({nm, " m1_err"},    {31'd0, m1_err},    32'd0);
    check({nm, " m0_rdata"},  m0_rdata,           32'd0);
    check({nm, " m1_rdata"},  m1_rdata,           32'd0);
    check({nm, " mem_we"},    {31'd0, mem_we},    32'd0);
    check({nm, " mem_a"},     mem_a,              32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic lock_pat [0:8];
    logic gnt1_pat [0:8];
    rstn = 1'b0;
    m1_lock = 1'b0;
    set_m0(1, 0, 4'h0, 32'h10, 32'h0);
    set_m1(1, 0, 4'h0, 32'h04, 32'h0);

    // Reset state, with both masters requesting: nothing may be granted.
    #12;
    check_quiet("reset");
    set_m0(0, 0, 4'h0, 32'h0, 32'h0);
    set_m1(0, 0, 4'h0, 32'h0, 32'h0);
    @(negedge clk);
    rstn = 1'b1;
    advance();

    // Preload memory through the arbiter with full-word writes.
    set_m0(1, 1, 4'hF, 32'h10, 32'hDEADBEEF);
    sample(1, 0, "pre 0x10");
    check("pre 0x10 mem_we", {31'd0, mem_we}, 32'd1);
    check("pre 0x10 mem_a",  mem_a,  32'h10);
    check("pre 0x10 mem_wd", mem_wd, 32'hDEADBEEF);
    advance();
    set_m0(1, 1, 4'hF, 32'h00, 32'h11110000); step(1, 0, "pre 0x00");
    set_m0(1, 1, 4'hF, 32'h04, 32'h22220001); step(1, 0, "pre 0x04");
    set_m0(1, 1, 4'hF, 32'h20, 32'hCAFEF00D); step(1, 0, "pre 0x20");
    set_m0(0, 0, 4'h0, 32'h0, 32'h0);
    set_m1(1, 1, 4'hF, 32'h24, 32'h00000000); step(0, 1, "pre 0x24");
    set_m1(0, 0, 4'h0, 32'h0, 32'h0);
    step(0, 0, "pre idle");

    // Single m0 read after reset.
    do_reset();
    set_m0(1, 0, 4'h0, 32'h10, 32'h0);
    expect_rd(0, 32'hDEADBEEF);
    step(1, 0, "rd 0x10");
    set_m0(0, 0, 4'h0, 32'h0, 32'h0);
    step(0, 0, "rd idle");
    step(0, 0, "rd idle2");

    // Continuous contention without lock alternates, m0 first.
    do_reset();
    set_m0(1, 0, 4'h0, 32'h00, 32'h0);
    set_m1(1, 0, 4'h0, 32'h04, 32'h0);
    for (int i = 0; i < 6; i++) begin
      if (i % 2 == 0) begin
        expect_rd(0, 32'h11110000);
        step(1, 0, $sformatf("alt %0d", i));
      end else begin
        expect_rd(1, 32'h22220001);
        step(0, 1, $sformatf("alt %0d", i));
      end
    end
    set_m0(0, 0, 4'h0, 32'h0, 32'h0);
    set_m1(0, 0, 4'h0, 32'h0, 32'h0);
    step(0, 0, "alt idle");

    // Locked m1 burst bounded at 4 grants, then m0, then alternation.
    do_reset();
    lock_pat = '{1, 1, 1, 1, 1, 1, 0, 0, 0};
    gnt1_pat = '{0, 1, 1, 1, 1, 0, 1, 0, 1};
    set_m0(1, 0, 4'h0, 32'h00, 32'h0);
    set_m1(1, 0, 4'h0, 32'h04, 32'h0);
    for (int i = 0; i < 9; i++) begin
      m1_lock = lock_pat[i];
      if (gnt1_pat[i]) expect_rd(1, 32'h22220001);
      else             expect_rd(0, 32'h11110000);
      step(!gnt1_pat[i], gnt1_pat[i], $sformatf("lock %0d", i));
    end
    m1_lock = 1'b0;
    set_m0(0, 0, 4'h0, 32'h0, 32'h0);
    set_m1(0, 0, 4'h0, 32'h0, 32'h0);
    step(0, 0, "lock idle");

    // Illegal lane mask: consumed, not written, error pulse.
    set_m0(1, 1, 4'b0101, 32'h20, 32'h12345678);
    expect_err(0);
    sample(1, 0, "bad wr");
    check("bad wr mem_we", {31'd0, mem_we}, 32'd0);
    advance();
    set_m0(1, 0, 4'h0, 32'h20, 32'h0);
    expect_rd(0, 32'hCAFEF00D);
    step(1, 0, "bad wr readback");
    set_m0(0, 0, 4'h0, 32'h0, 32'h0);
    step(0, 0, "bad wr idle");

    // m1 byte store to lane 2, then readback.
    set_m1(1, 1, 4'b0100, 32'h24, 32'h000000AB);
    sample(0, 1, "sb");
    check("sb mem_we",  {31'd0, mem_we}, 32'd1);
    check("sb mem_amp", {28'd0, mem_amp}, 32'h4);
    check("sb mem_a",   mem_a,  32'h24);
    check("sb mem_wd",  mem_wd, 32'h000000AB);
    advance();
    set_m1(1, 0, 4'h0, 32'h24, 32'h0);
    expect_rd(1, 32'h00AB0000);
    step(0, 1, "sb readback");
    set_m1(1, 1, 4'b0110, 32'h24, 32'hFFFFFFFF);
    expect_err(1);
    step(0, 1, "m1 bad wr");
    set_m1(1, 0, 4'h0, 32'h24, 32'h0);
    expect_rd(1, 32'h00AB0000);
    step(0, 1, "m1 bad wr readback");
    set_m1(0, 0, 4'h0, 32'h0, 32'h0);
    step(0, 0, "sb idle");

    // Reset in the middle of a locked m1 burst.
    do_reset();
    m1_lock = 1'b1;
    set_m1(1, 0, 4'h0, 32'h04, 32'h0);
    expect_rd(1, 32'h22220001);
    step(0, 1, "burst 0");
    set_m0(1, 0, 4'h0, 32'h00, 32'h0);
    expect_rd(1, 32'h22220001);
    step(0, 1, "burst 1");
    rstn = 1'b0;
    #1;
    check_quiet("mid-burst reset");
    q1.delete();
    set_m0(0, 0, 4'h0, 32'h0, 32'h0);
    set_m1(0, 0, 4'h0, 32'h0, 32'h0);
    advance();
    @(negedge clk);
    rstn = 1'b1;
    advance();
    set_m0(1, 0, 4'h0, 32'h00, 32'h0);
    set_m1(1, 0, 4'h0, 32'h04, 32'h0);
    expect_rd(0, 32'h11110000);
    step(1, 0, "post-reset 0");
    expect_rd(1, 32'h22220001);
    step(0, 1, "post-reset 1");
    expect_rd(1, 32'h22220001);
    step(0, 1, "post-reset 2");
    m1_lock = 1'b0;
    set_m0(0, 0, 4'h0, 32'h0, 32'h0);
    set_m1(0, 0, 4'h0, 32'h0, 32'h0);
    step(0, 0, "final idle");
    step(0, 0, "final idle2");

    check("m0 queue drained", q0.size(), 32'd0);
    check("m1 queue drained", q1.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
